// File: rtl/xspi_sopi_target.sv
// Octal xSPI target endpoint: decodes cmd/48-bit addr with CRC8 protection and
// services 64-bit writes (0xA5) and reads (0xFF) against a local word array.
module xspi_sopi_target #(
  parameter int MEM_AW       = 4,
  parameter int READ_LATENCY = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic [7:0]        io_in,
  output logic [7:0]        io_out,
  output logic              io_oe,
  output logic              data_strobe,
  output logic              crc_ca_error,
  output logic              crc_data_error,
  output logic              wr_commit,
  output logic [MEM_AW-1:0] wr_addr,
  output logic              busy
);

  localparam int DEPTH = 2 ** MEM_AW;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_CA_CRC, S_WR_DATA, S_WR_CRC,
    S_RD_ECHO, S_RD_LAT, S_RD_DATA, S_RD_CRC, S_WAIT_CS
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        ca_crc_q, ca_crc_d;
  logic [7:0]        dat_crc_q, dat_crc_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              ca_err_q, ca_err_d;
  logic              dat_err_q, dat_err_d;
  logic              wr_commit_q, wr_commit_d;
  logic              mem_we;
  logic [63:0]       mem_q [DEPTH];

  // CRC8, polynomial x^8+x^2+x+1, MSB first, one byte per call.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] din);
    logic [7:0] r;
    r = crc ^ din;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    ca_crc_d    = ca_crc_q;
    dat_crc_d   = dat_crc_q;
    addr_d      = addr_q;
    wr_addr_d   = wr_addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ca_err_d    = ca_err_q;
    dat_err_d   = dat_err_q;
    wr_commit_d = 1'b0;
    mem_we      = 1'b0;
    io_oe       = 1'b0;
    io_out      = 8'h00;
    data_strobe = 1'b0;

    case (state_q)
      S_RD_ECHO: begin io_oe = 1'b1; io_out = ca_crc_q; end
      S_RD_LAT:  io_oe = 1'b1;
      S_RD_DATA: begin io_oe = 1'b1; data_strobe = 1'b1; io_out = rdata_q[63:56]; end
      S_RD_CRC:  begin io_oe = 1'b1; data_strobe = 1'b1; io_out = dat_crc_q; end
      default: ;
    endcase

    if (state_q == S_IDLE) begin
      ca_crc_d  = 8'h00;
      dat_crc_d = 8'h00;
      if (!cs_n) begin
        cmd_d     = io_in;
        ca_crc_d  = crc8_step(8'h00, io_in);
        ca_err_d  = 1'b0;
        dat_err_d = 1'b0;
        cnt_d     = 8'd0;
        state_d   = S_ADDR;
      end
    end else if (cs_n) begin
      // Abort: anything in flight is dropped, including an uncommitted write.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_ADDR: begin
          addr_d   = MEM_AW'({addr_q, io_in});
          ca_crc_d = crc8_step(ca_crc_q, io_in);
          cnt_d    = cnt_q + 8'd1;
          if (cnt_q == 8'd5) state_d = S_CA_CRC;
        end
        S_CA_CRC: begin
          cnt_d   = 8'd0;
          state_d = S_WAIT_CS;
          if (io_in != ca_crc_q) begin
            ca_err_d = 1'b1;
          end else if (cmd_q == 8'hA5) begin
            state_d = S_WR_DATA;
          end else if (cmd_q == 8'hFF) begin
            rdata_d = mem_q[addr_q];
            state_d = S_RD_ECHO;
          end
        end
        S_WR_DATA: begin
          wdata_d   = {wdata_q[55:0], io_in};
          dat_crc_d = crc8_step(dat_crc_q, io_in);
          cnt_d     = cnt_q + 8'd1;
          if (cnt_q == 8'd7) state_d = S_WR_CRC;
        end
        S_WR_CRC: begin
          if (io_in == dat_crc_q) begin
            mem_we      = 1'b1;
            wr_commit_d = 1'b1;
            wr_addr_d   = addr_q;
          end else begin
            dat_err_d = 1'b1;
          end
          state_d = S_WAIT_CS;
        end
        S_RD_ECHO: begin
          cnt_d   = 8'd0;
          state_d = (READ_LATENCY <= 1) ? S_RD_DATA : S_RD_LAT;
        end
        S_RD_LAT: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(READ_LATENCY - 2)) begin
            cnt_d   = 8'd0;
            state_d = S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          rdata_d   = {rdata_q[55:0], 8'h00};
          dat_crc_d = crc8_step(dat_crc_q, rdata_q[63:56]);
          cnt_d     = cnt_q + 8'd1;
          if (cnt_q == 8'd7) state_d = S_RD_CRC;
        end
        S_RD_CRC: state_d = S_WAIT_CS;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      cmd_q       <= '0;
      ca_crc_q    <= '0;
      dat_crc_q   <= '0;
      addr_q      <= '0;
      wr_addr_q   <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ca_err_q    <= 1'b0;
      dat_err_q   <= 1'b0;
      wr_commit_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      ca_crc_q    <= ca_crc_d;
      dat_crc_q   <= dat_crc_d;
      addr_q      <= addr_d;
      wr_addr_q   <= wr_addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ca_err_q    <= ca_err_d;
      dat_err_q   <= dat_err_d;
      wr_commit_q <= wr_commit_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign crc_ca_error   = ca_err_q;
  assign crc_data_error = dat_err_q;
  assign wr_commit      = wr_commit_q;
  assign wr_addr        = wr_addr_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_xspi_sopi_target.sv
// Randomized scoreboard bench for xspi_sopi_target: the driver queues expected
// bus bytes and commits, an independent monitor checks them as they appear.
module tb_xspi_sopi_target;

  localparam int AW = 4;
  localparam int RL = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs_n = 1'b1;
  logic [7:0]    io_in = 8'h00;
  logic [7:0]    io_out;
  logic          io_oe, data_strobe, crc_ca_error, crc_data_error, wr_commit, busy;
  logic [AW-1:0] wr_addr;

  xspi_sopi_target #(.MEM_AW(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .io_in(io_in), .io_out(io_out),
    .io_oe(io_oe), .data_strobe(data_strobe), .crc_ca_error(crc_ca_error),
    .crc_data_error(crc_data_error), .wr_commit(wr_commit), .wr_addr(wr_addr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] b; logic stb; } rd_exp_t;

  rd_exp_t       rd_q[$];
  logic [AW-1:0] commit_q[$];
  logic [63:0]   model_mem [2**AW];
  int            checks = 0;
  int            failures = 0;
  rd_exp_t       mon_e;
  logic [AW-1:0] mon_a;

  // Reference CRC: bit-serial long division over the whole message.
  function automatic logic [7:0] crc_ref(input logic [7:0] msg[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (msg[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ msg[i][k];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_read_exp(input logic [63:0] w, input logic [7:0] ca);
    logic [7:0] dq[$];
    rd_q.push_back('{b: ca, stb: 1'b0});
    for (int i = 0; i < RL - 1; i++) rd_q.push_back('{b: 8'h00, stb: 1'b0});
    for (int i = 7; i >= 0; i--) begin
      dq.push_back(w[8*i +: 8]);
      rd_q.push_back('{b: w[8*i +: 8], stb: 1'b1});
    end
    rd_q.push_back('{b: crc_ref(dq), stb: 1'b1});
  endtask

  task automatic drive(input logic c, input logic [7:0] d);
    @(posedge clk);
    #1;
    cs_n  = c;
    io_in = d;
  endtask

  // One framed transaction; abort_at >= 0 raises cs_n after that many bytes.
  task automatic xfer(input logic [7:0] cmd, input logic [47:0] addr, input logic [63:0] data,
                      input logic [7:0] ca_x, input logic [7:0] dat_x, input int abort_at);
    logic [7:0]    q[$];
    logic [7:0]    dq[$];
    logic [7:0]    ca;
    logic          is_wr, is_rd, done;
    logic [AW-1:0] idx;
    int            n;
    q.push_back(cmd);
    for (int i = 5; i >= 0; i--) q.push_back(addr[8*i +: 8]);
    ca = crc_ref(q);
    q.push_back(ca ^ ca_x);
    is_wr = (ca_x == 8'h00) && (cmd == 8'hA5);
    is_rd = (ca_x == 8'h00) && (cmd == 8'hFF);
    idx   = addr[AW-1:0];
    if (is_wr) begin
      for (int i = 7; i >= 0; i--) dq.push_back(data[8*i +: 8]);
      foreach (dq[i]) q.push_back(dq[i]);
      q.push_back(crc_ref(dq) ^ dat_x);
    end
    if (is_rd) for (int i = 0; i < RL + 9; i++) q.push_back(8'h00);
    n    = (abort_at >= 0 && abort_at < q.size()) ? abort_at : q.size();
    done = (n == q.size());
    if (done && is_wr && dat_x == 8'h00) begin
      commit_q.push_back(idx);
      model_mem[idx] = data;
    end
    if (done && is_rd) push_read_exp(model_mem[idx], ca);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, q[i]);
      if (i == 1) check("flags_clear_on_start", {crc_ca_error, crc_data_error}, 2'b00);
    end
    if (done) begin
      drive(1'b0, 8'h00);
      drive(1'b0, 8'h00);
    end
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h00);
    check("busy_after_cs_rise", busy, 1'b0);
    check("ca_flag", crc_ca_error, (ca_x != 8'h00) && (n >= 8));
    check("data_flag", crc_data_error, done && is_wr && (dat_x != 8'h00));
  endtask

  // Monitor: every output byte and commit pulse is matched against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (io_oe) begin
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_drive io_out=%02h expected io_oe=0", io_out);
        end else begin
          mon_e = rd_q.pop_front();
          if (io_out !== mon_e.b || data_strobe !== mon_e.stb) begin
            failures++;
            $display("FAIL rd_byte got=%02h/%b expected=%02h/%b", io_out, data_strobe, mon_e.b, mon_e.stb);
          end
        end
      end else begin
        checks++;
        if (io_out !== 8'h00 || data_strobe !== 1'b0) begin
          failures++;
          $display("FAIL idle_bus got=%02h/%b expected=00/0", io_out, data_strobe);
        end
      end
      if (wr_commit) begin
        checks++;
        if (commit_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_commit wr_addr=%0h expected no commit", wr_addr);
        end else begin
          mon_a = commit_q.pop_front();
          if (wr_addr !== mon_a) begin
            failures++;
            $display("FAIL wr_addr got=%0h expected=%0h", wr_addr, mon_a);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0]  hq[$];
    logic [7:0]  cmd, ca_x, dat_x;
    logic [47:0] addr;
    logic [63:0] data;
    int          abort_at;
    for (int i = 0; i < 2**AW; i++) model_mem[i] = 64'h0;
    #23;
    check("reset_outputs", {io_out, io_oe, data_strobe, crc_ca_error, crc_data_error, wr_commit, wr_addr, busy}, '0);
    rst_n = 1'b1;
    drive(1'b1, 8'h00);

    xfer(8'hA5, 48'h3, 64'h0123456789ABCDEF, 8'h00, 8'h00, -1);
    xfer(8'hFF, 48'h3, 64'h0, 8'h00, 8'h00, -1);
    xfer(8'hA5, 48'h3, 64'hDEADBEEFCAFEF00D, 8'h01, 8'h00, -1);
    xfer(8'hFF, 48'h3, 64'h0, 8'h00, 8'h00, -1);
    xfer(8'hA5, 48'h3, 64'h1122334455667788, 8'h00, 8'h5A, -1);
    xfer(8'hA5, 48'h3, 64'h1122334455667788, 8'h00, 8'h00, -1);
    xfer(8'hA5, 48'h5, 64'hFFFF0000FFFF0000, 8'h00, 8'h00, 12);
    xfer(8'hA5, 48'h5, 64'h0F0F0F0F0F0F0F0F, 8'h00, 8'h00, -1);
    xfer(8'hFF, 48'h5, 64'h0, 8'h00, 8'h00, -1);
    xfer(8'h3C, 48'h3, 64'h0, 8'h00, 8'h00, -1);
    xfer(8'hA5, 48'hABCDEF012347, 64'h8000000000000001, 8'h00, 8'h00, -1);
    xfer(8'hFF, 48'h000000000007, 64'h0, 8'h00, 8'h00, -1);

    // Reset in the middle of a read data phase.
    hq = {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
    push_read_exp(model_mem[3], crc_ref(hq));
    hq.push_back(crc_ref(hq));
    foreach (hq[i]) drive(1'b0, hq[i]);
    for (int i = 0; i < RL + 3; i++) drive(1'b0, 8'h00);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_read_reset", {io_out, io_oe, data_strobe, crc_ca_error, crc_data_error, wr_commit, wr_addr, busy}, '0);
    rd_q.delete();
    commit_q.delete();
    for (int i = 0; i < 2**AW; i++) model_mem[i] = 64'h0;
    cs_n = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 8'h00);
    xfer(8'hFF, 48'h3, 64'h0, 8'h00, 8'h00, -1);

    for (int t = 0; t < 40; t++) begin
      addr = {16'($urandom), 32'($urandom)};
      data = {32'($urandom), 32'($urandom)};
      case ($urandom_range(0, 9))
        0, 1, 2, 3: cmd = 8'hA5;
        4, 5, 6, 7: cmd = 8'hFF;
        default:    cmd = 8'($urandom);
      endcase
      ca_x     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      dat_x    = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      abort_at = (cmd == 8'hA5 && $urandom_range(0, 6) == 0) ? int'($urandom_range(1, 16)) : -1;
      xfer(cmd, addr, data, ca_x, dat_x, abort_at);
    end

    drive(1'b1, 8'h00);
    check("rd_queue_drained", rd_q.size(), 0);
    check("commit_queue_drained", commit_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
